// File: rtl/neuron_mac.sv
// Binary-input perceptron MAC: captures inputs, weights and threshold on start, then adds one gated weight per cycle.
// Build option: define ACC_SAT_EN for a saturating accumulator; otherwise each add wraps.
//
// state | meaning
// IDLE  | waiting for start_i; sum_o/fire_o hold the last result
// ACCUM | adding one gated weight per cycle, idx 0..7
// DONE  | result valid for one cycle (done_o); start_i is accepted here too
module neuron_mac #(
    parameter int WIDTH_P     = 4,
    parameter int ACC_WIDTH_P = WIDTH_P + 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [7:0]             x_i,
    input  logic [WIDTH_P-1:0]     weight_0,
    input  logic [WIDTH_P-1:0]     weight_1,
    input  logic [WIDTH_P-1:0]     weight_2,
    input  logic [WIDTH_P-1:0]     weight_3,
    input  logic [WIDTH_P-1:0]     weight_4,
    input  logic [WIDTH_P-1:0]     weight_5,
    input  logic [WIDTH_P-1:0]     weight_6,
    input  logic [WIDTH_P-1:0]     weight_7,
    input  logic [ACC_WIDTH_P-1:0] thresh_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [ACC_WIDTH_P-1:0] sum_o,
    output logic                   fire_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [ACC_WIDTH_P-1:0] acc_q, acc_d;
    logic [7:0]             x_q, x_d;
    logic [WIDTH_P-1:0]     w_q [8];
    logic [WIDTH_P-1:0]     w_d [8];
    logic [ACC_WIDTH_P-1:0] thr_q, thr_d;
    logic [ACC_WIDTH_P-1:0] sum_q, sum_d;
    logic                   fire_q, fire_d;

    logic [WIDTH_P-1:0]     w_in [8];
    logic [ACC_WIDTH_P-1:0] term;
    logic [ACC_WIDTH_P:0]   add_full;
    logic [ACC_WIDTH_P-1:0] acc_nxt;
    logic                   capture;

    assign w_in[0] = weight_0;
    assign w_in[1] = weight_1;
    assign w_in[2] = weight_2;
    assign w_in[3] = weight_3;
    assign w_in[4] = weight_4;
    assign w_in[5] = weight_5;
    assign w_in[6] = weight_6;
    assign w_in[7] = weight_7;

    // Upstream weights change every clock, so everything is taken from the captured copies.
    always_comb begin
        term     = x_q[idx_q] ? ACC_WIDTH_P'(w_q[idx_q]) : '0;
        add_full = {1'b0, acc_q} + {1'b0, term};
`ifdef ACC_SAT_EN
        acc_nxt  = add_full[ACC_WIDTH_P] ? '1 : add_full[ACC_WIDTH_P-1:0];
`else
        acc_nxt  = add_full[ACC_WIDTH_P-1:0];
`endif
    end

    // DONE accepts start as well, giving a 9-cycle start-to-start period.
    assign capture = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        x_d     = x_q;
        w_d     = w_q;
        thr_d   = thr_q;
        sum_d   = sum_q;
        fire_d  = fire_q;

        case (state_q)
            ST_IDLE: begin
                if (capture) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                acc_d = acc_nxt;
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    sum_d   = acc_nxt;
                    fire_d  = (acc_nxt >= thr_q);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = capture ? ST_ACCUM : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (capture) begin
            x_d   = x_i;
            w_d   = w_in;
            thr_d = thresh_i;
            acc_d = '0;
            idx_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            for (int k = 0; k < 8; k++) w_q[k] <= '0;
            thr_q   <= '0;
            sum_q   <= '0;
            fire_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            w_q     <= w_d;
            thr_q   <= thr_d;
            sum_q   <= sum_d;
            fire_q  <= fire_d;
        end
    end

    assign busy_o = (state_q == ST_ACCUM) || (state_q == ST_DONE);
    assign done_o = (state_q == ST_DONE);
    assign sum_o  = sum_q;
    assign fire_o = fire_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: default-width DUT plus a 5-bit accumulator instance for overflow behaviour.
module tb_neuron_mac;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start, start2;
    logic [7:0] x;
    logic [3:0] w [8];
    logic [6:0] thr;
    logic [4:0] thr5;

    logic       busy_o, done_o, fire_o;
    logic [6:0] sum_o;
    logic       busy2, done2, fire2;
    logic [4:0] sum2;

    neuron_mac dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .x_i(x),
        .weight_0(w[0]), .weight_1(w[1]), .weight_2(w[2]), .weight_3(w[3]),
        .weight_4(w[4]), .weight_5(w[5]), .weight_6(w[6]), .weight_7(w[7]),
        .thresh_i(thr), .busy_o(busy_o), .done_o(done_o), .sum_o(sum_o), .fire_o(fire_o)
    );

    neuron_mac #(.WIDTH_P(4), .ACC_WIDTH_P(5)) dut5 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .x_i(x),
        .weight_0(w[0]), .weight_1(w[1]), .weight_2(w[2]), .weight_3(w[3]),
        .weight_4(w[4]), .weight_5(w[5]), .weight_6(w[6]), .weight_7(w[7]),
        .thresh_i(thr5), .busy_o(busy2), .done_o(done2), .sum_o(sum2), .fire_o(fire2)
    );

    typedef struct {
        int st;
        int sum;
        bit fire;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   nxt_ok = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: a start is taken at most once per 9 edges; the result is the gated weight sum.
    always @(posedge clk) begin
        int   s;
        exp_t e;
        cyc++;
        if (!rst_n) begin
            nxt_ok = 0;
        end else if (start && cyc >= nxt_ok) begin
            s = 0;
            for (int k = 0; k < 8; k++) if (x[k]) s += int'(w[k]);
            e.st   = cyc;
            e.sum  = s;
            e.fire = (s >= int'(thr));
            sb.push_back(e);
            nxt_ok = cyc + 9;
        end
    end

    always @(negedge clk) begin
        bit exp_d;
        if (rst_n) begin
            exp_d = (sb.size() > 0) && (sb[0].st + 8 == cyc);
            if (done_o || exp_d) begin
                chk("done_timing", done_o, exp_d);
                if (exp_d) begin
                    chk("sum", sum_o, sb[0].sum);
                    chk("fire", fire_o, sb[0].fire);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic drive_op(input logic [7:0] xv, input int wv[8], input int tv);
        @(negedge clk);
        x = xv;
        for (int k = 0; k < 8; k++) w[k] = 4'(wv[k]);
        thr   = 7'(tv);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy_o, 1);
        x   = 8'($urandom);
        thr = 7'($urandom);
        for (int k = 0; k < 8; k++) w[k] = 4'($urandom);
        repeat (10) @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_sum"},  sum_o,  0);
        chk({tag, "_fire"}, fire_o, 0);
    endtask

    initial begin
        int wv[8];
        int held;
        bit seen;

        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; x = '0; thr = '0; thr5 = '0;
        for (int k = 0; k < 8; k++) w[k] = '0;
        #1 check_cleared("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // All inputs on, weight 3 each: sum 24 meets threshold 24.
        for (int k = 0; k < 8; k++) wv[k] = 3;
        drive_op(8'hFF, wv, 24);
        chk("hold_sum", sum_o, 24);

        // Only input 0: sum 5 below threshold 6.
        wv[0] = 5;
        for (int k = 1; k < 8; k++) wv[k] = 7;
        drive_op(8'h01, wv, 6);

        // Reset while idle clears everything with no clock edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_cleared("rst_idle");
        @(negedge clk);
        rst_n = 1'b1;

        // Weight k = k, pattern A5, zero threshold always fires.
        for (int k = 0; k < 8; k++) wv[k] = k;
        drive_op(8'hA5, wv, 0);
        chk("hold_sum_a5", sum_o, 14);
        chk("hold_fire_a5", fire_o, 1);

        // start held high with inputs churning every cycle: back-to-back ops.
        @(negedge clk);
        x = 8'($urandom); thr = 7'($urandom);
        for (int k = 0; k < 8; k++) w[k] = 4'($urandom);
        start = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            x = 8'($urandom); thr = 7'($urandom);
            for (int k = 0; k < 8; k++) w[k] = 4'($urandom);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("b2b_drained", sb.size(), 0);

        // Reset during ACCUM aborts without a done pulse.
        @(negedge clk);
        x = 8'hFF; thr = 7'd1;
        for (int k = 0; k < 8; k++) w[k] = 4'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1 check_cleared("rst_accum");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) wv[k] = 15;
        drive_op(8'hC3, wv, 61);
        chk("post_rst_sum", sum_o, 60);
        chk("post_rst_fire", fire_o, 0);

        // Narrow accumulator: 8 x 7 = 56 overflows 5 bits.
        @(negedge clk);
        x = 8'hFF; thr5 = 5'd31;
        for (int k = 0; k < 8; k++) w[k] = 4'd7;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done2) seen = 1'b1;
        end
        chk("narrow_done_seen", seen, 1);
`ifdef ACC_SAT_EN
        chk("narrow_sum", sum2, 31);
        chk("narrow_fire", fire2, 1);
`else
        chk("narrow_sum", sum2, 24);
        chk("narrow_fire", fire2, 0);
`endif
        held = int'(sum2);
        repeat (3) @(negedge clk);
        chk("narrow_hold", sum2, held);

        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
